// File: rtl/fifo.sv
// Synchronous FIFO with registered read data and request handshake pulses.
// Define FIFO_ASSERT_EN to compile the built-in protocol assertions.
module fifo #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_ok, rd_ok;

   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q == DEPTH_C - ONE_C);
   assign almostempty = (count_q == ONE_C);

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      wr_ack_d    = wr_ok;
      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         data_out_d = mem_q[rd_ptr_q];
      end
      // Occupancy only moves when exactly one side is accepted.
      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign wr_ack    = wr_ack_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef FIFO_ASSERT_EN
   a_wr_accept: assert property (@(posedge clk) disable iff (rst)
      (wr_en && !full) |=> (wr_ack && !overflow));
   a_wr_reject: assert property (@(posedge clk) disable iff (rst)
      (wr_en && full) |=> (overflow && !wr_ack));
   a_rd_accept: assert property (@(posedge clk) disable iff (rst)
      (rd_en && !empty) |=> (!underflow
         && rd_ptr_q == $past(rd_ptr_q) + AW'(1)));
   a_rd_reject: assert property (@(posedge clk) disable iff (rst)
      (rd_en && empty) |=> (underflow && $stable(data_out)));
   a_flags: assert property (@(posedge clk)
      (full == (count_q == DEPTH_C)) && (empty == (count_q == '0))
      && (almostfull == (count_q == DEPTH_C - ONE_C))
      && (almostempty == (count_q == ONE_C)));
   always_comb begin
      if (rst) begin
         a_rst_flags: assert final (empty && !full
            && !almostfull && !almostempty);
      end
   end
`else
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: fill, overflow, drain, underflow,
// wrap-around streaming and asynchronous mid-burst reset.
module tb_fifo;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] data_out;
   logic        wr_ack;
   logic        overflow;
   logic        underflow;
   logic        full;
   logic        empty;
   logic        almostfull;
   logic        almostempty;

   int vectors;
   int miscompares;
   logic [15:0] model_q[$];
   logic [15:0] exp_w;

   fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .empty       (empty),
      .almostfull  (almostfull),
      .almostempty (almostempty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      data_in = '0;
      step();
      step();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_afull", 32'(almostfull), 32'd0);
      check("rst_aempty", 32'(almostempty), 32'd0);
      check("rst_dout", 32'(data_out), 32'h0);
      check("rst_pulses", {29'd0, wr_ack, overflow, underflow}, 32'd0);
      rst = 1'b0;
      step();

      // Fill with 1..8
      for (int i = 1; i <= 8; i++) begin
         data_in = 16'(i);
         wr_en = 1'b1;
         step();
         check($sformatf("fill_ack%0d", i), 32'(wr_ack), 32'd1);
         check($sformatf("fill_afull%0d", i), 32'(almostfull),
               (i == 7) ? 32'd1 : 32'd0);
         check($sformatf("fill_full%0d", i), 32'(full),
               (i == 8) ? 32'd1 : 32'd0);
      end

      data_in = 16'hFFFF;
      step();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_ack", 32'(wr_ack), 32'd0);
      check("ovf_full", 32'(full), 32'd1);
      wr_en = 1'b0;

      // Drain, expecting write order and no 0xFFFF
      for (int i = 1; i <= 8; i++) begin
         rd_en = 1'b1;
         step();
         check($sformatf("drain_data%0d", i), 32'(data_out), 32'(i));
         check($sformatf("drain_aempty%0d", i), 32'(almostempty),
               (i == 7) ? 32'd1 : 32'd0);
         check($sformatf("drain_empty%0d", i), 32'(empty),
               (i == 8) ? 32'd1 : 32'd0);
      end
      rd_en = 1'b0;
      step();
      check("idle_hold", 32'(data_out), 32'h8);
      check("idle_ovf", 32'(overflow), 32'd0);
      check("idle_unf", 32'(underflow), 32'd0);

      rd_en = 1'b1;
      step();
      check("unf_flag", 32'(underflow), 32'd1);
      check("unf_hold", 32'(data_out), 32'h8);

      wr_en = 1'b1;
      data_in = 16'h00AA;
      step();
      check("both_empty_unf", 32'(underflow), 32'd1);
      check("both_empty_ack", 32'(wr_ack), 32'd1);
      check("both_empty_aempty", 32'(almostempty), 32'd1);
      check("both_empty_hold", 32'(data_out), 32'h8);
      rd_en = 1'b0;
      model_q.push_back(16'h00AA);

      for (int k = 1; k <= 2; k++) begin
         data_in = 16'(16'hB0 + k);
         model_q.push_back(data_in);
         step();
      end
      wr_en = 1'b0;
      step();
      check("cnt3_aempty", 32'(almostempty), 32'd0);
      check("cnt3_empty", 32'(empty), 32'd0);

      // Stream at count 3 across pointer wrap
      for (int k = 0; k < 10; k++) begin
         wr_en = 1'b1;
         rd_en = 1'b1;
         data_in = 16'(16'hC0 + k);
         exp_w = model_q.pop_front();
         model_q.push_back(data_in);
         step();
         check($sformatf("stream_data%0d", k), 32'(data_out),
               32'(exp_w));
         check($sformatf("stream_flags%0d", k),
               {28'd0, full, empty, almostfull, almostempty}, 32'd0);
         check($sformatf("stream_ack%0d", k), 32'(wr_ack), 32'd1);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;

      // Mid-burst reset, no clock edge between assert and check
      wr_en = 1'b1;
      data_in = 16'h0055;
      step();
      step();
      rst = 1'b1;
      #1;
      check("mrst_empty", 32'(empty), 32'd1);
      check("mrst_flags", {29'd0, full, almostfull, almostempty},
            32'd0);
      check("mrst_dout", 32'(data_out), 32'h0);
      check("mrst_pulses", {29'd0, wr_ack, overflow, underflow},
            32'd0);
      step();
      check("mrst_ignore", 32'(empty), 32'd1);
      rst = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      check("post_rst_unf", 32'(underflow), 32'd1);
      rd_en = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
